// File: rtl/hazard_responder.sv
// Stall-request consumer: turns one-cycle hazard requests into per-stage write
// enables and bubble controls, counting multi-cycle holds internally.
module hazard_responder #(
    parameter int unsigned CTRL_SHADOW = 2,
    parameter int unsigned LW_SHADOW   = 1,
    parameter int unsigned PERF_W      = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              jb_req,
    input  logic              lw_req,
    input  logic              redirect,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_bubble,
    output logic              idex_bubble,
    output logic              busy,
    output logic              proto_err,
    output logic [PERF_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StLw   = 2'b01,
        StCtrl = 2'b10
    } state_e;

    localparam logic [1:0] CtrlInit = 2'(CTRL_SHADOW - 1);
    localparam logic [1:0] LwInit   = 2'(LW_SHADOW - 1);
    localparam bit         LwHolds  = (LW_SHADOW > 1);

    state_e            state_q, state_d;
    logic [1:0]        hold_q, hold_d;
    logic              proto_err_q, proto_err_d;
    logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

    logic pc_we_c, ifid_we_c, ifid_bubble_c, idex_bubble_c;
    logic release_c;

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        pc_we_c       = 1'b1;
        ifid_we_c     = 1'b1;
        ifid_bubble_c = 1'b0;
        idex_bubble_c = 1'b0;
        release_c     = 1'b0;

        case (state_q)
            StIdle: begin
                if (lw_req) begin
                    // Load-use wins; a simultaneous branch stays frozen in stage 1.
                    pc_we_c       = 1'b0;
                    ifid_we_c     = 1'b0;
                    idex_bubble_c = 1'b1;
                    if (LwHolds) begin
                        state_d = StLw;
                        hold_d  = LwInit;
                    end
                end else if (jb_req) begin
                    pc_we_c       = 1'b0;
                    ifid_bubble_c = 1'b1;
                    state_d       = StCtrl;
                    hold_d        = CtrlInit;
                end
            end
            StLw: begin
                pc_we_c       = 1'b0;
                ifid_we_c     = 1'b0;
                idex_bubble_c = 1'b1;
                if (hold_q == 2'd1) begin
                    state_d = StIdle;
                    hold_d  = 2'd0;
                end else begin
                    hold_d = hold_q - 2'd1;
                end
            end
            StCtrl: begin
                ifid_bubble_c = 1'b1;
                release_c     = redirect | (hold_q == 2'd1);
                pc_we_c       = release_c;
                if (release_c) begin
                    state_d = StIdle;
                    hold_d  = 2'd0;
                end else begin
                    hold_d = hold_q - 2'd1;
                end
            end
            default: begin
                state_d = StIdle;
                hold_d  = 2'd0;
            end
        endcase
    end

    always_comb begin
        proto_err_d = proto_err_q | (redirect & (state_q != StCtrl));
        stall_cnt_d = stall_cnt_q;
        if (!pc_we_c && (stall_cnt_q != {PERF_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= StIdle;
            hold_q      <= 2'd0;
            proto_err_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            proto_err_q <= proto_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Enables are forced low while reset is held so no stage loads garbage.
    assign pc_we       = RSTn & pc_we_c;
    assign ifid_we     = RSTn & ifid_we_c;
    assign ifid_bubble = RSTn & ifid_bubble_c;
    assign idex_bubble = RSTn & idex_bubble_c;
    assign busy        = RSTn & (state_q != StIdle);
    assign proto_err   = proto_err_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
